// File: rtl/inverse_diffusion_layer.sv
// Inverse Ascon linear layer: recovers the pre-diffusion state by applying L^63 as six
// squared-map steps per row. Define INV_DIFFUSION_UNROLL2_EN to apply two steps per clock.
module inverse_diffusion_layer (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             start_i,
    input  logic [4:0][63:0] diffused_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             valid_o,
    output logic [4:0][63:0] target_o
);

    localparam logic [5:0] RotA [5] = '{6'd19, 6'd61, 6'd1, 6'd10, 6'd7};
    localparam logic [5:0] RotB [5] = '{6'd28, 6'd39, 6'd6, 6'd17, 6'd41};

`ifdef INV_DIFFUSION_UNROLL2_EN
    localparam logic [2:0] LastCnt = 3'd2;
`else
    localparam logic [2:0] LastCnt = 3'd5;
`endif

    typedef enum logic {StIdle, StRun} state_e;

    state_e           fsm_q, fsm_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [4:0][63:0] data_q, data_d;
    logic [4:0][63:0] stepped;
    logic [2:0]       step_idx;
    logic             done_q, done_d;
    logic             valid_q, valid_d;

    function automatic logic [63:0] ror64(input logic [63:0] x, input logic [5:0] n);
        logic [127:0] dbl;
        dbl = {x, x} >> n;
        return dbl[63:0];
    endfunction

    // Step k is L squared k times, so both rotations scale by 2^k; the 6-bit shift wraps mod 64.
    function automatic logic [63:0] inv_step(input logic [63:0] x, input logic [5:0] a,
                                             input logic [5:0] b, input logic [2:0] k);
        logic [63:0] res;
        res = x;
        for (int s = 0; s < 6; s++) begin
            if (3'(s) == k) begin
                res = x ^ ror64(x, a << s) ^ ror64(x, b << s);
            end
        end
        return res;
    endfunction

`ifdef INV_DIFFUSION_UNROLL2_EN
    assign step_idx = (fsm_q == StIdle) ? 3'd0 : (cnt_q << 1);
`else
    assign step_idx = (fsm_q == StIdle) ? 3'd0 : cnt_q;
`endif

    always_comb begin
        stepped = '0;
        for (int r = 0; r < 5; r++) begin
`ifdef INV_DIFFUSION_UNROLL2_EN
            stepped[r] = inv_step(inv_step((fsm_q == StIdle) ? diffused_i[r] : data_q[r],
                                           RotA[r], RotB[r], step_idx),
                                  RotA[r], RotB[r], step_idx + 3'd1);
`else
            stepped[r] = inv_step((fsm_q == StIdle) ? diffused_i[r] : data_q[r],
                                  RotA[r], RotB[r], step_idx);
`endif
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        unique case (fsm_q)
            StIdle: begin
                if (start_i) begin
                    data_d  = stepped;
                    cnt_d   = 3'd1;
                    fsm_d   = StRun;
                    valid_d = 1'b0;
                end
            end
            StRun: begin
                data_d = stepped;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == LastCnt) begin
                    fsm_d   = StIdle;
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q   <= StIdle;
            cnt_q   <= 3'd0;
            data_q  <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    assign busy_o   = (fsm_q == StRun);
    assign done_o   = done_q;
    assign valid_o  = valid_q;
    assign target_o = data_q;

endmodule

// File: tb/tb_inverse_diffusion_layer.sv
// Bench for inverse_diffusion_layer: feeds forward-diffused states and expects the originals
// back, plus handshake, held-start and mid-run reset scenarios.
module tb_inverse_diffusion_layer;

`ifdef INV_DIFFUSION_UNROLL2_EN
    localparam int Lat = 3;
`else
    localparam int Lat = 6;
`endif

    localparam int FwdA [5] = '{19, 61, 1, 10, 7};
    localparam int FwdB [5] = '{28, 39, 6, 17, 41};

    typedef logic [4:0][63:0] st_t;

    logic clk   = 1'b0;
    logic rstn  = 1'b0;
    logic start = 1'b0;
    st_t  din   = '0;
    logic busy, done, valid;
    st_t  tgt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inverse_diffusion_layer dut (
        .clock_i    (clk),
        .resetb_i   (rstn),
        .start_i    (start),
        .diffused_i (din),
        .busy_o     (busy),
        .done_o     (done),
        .valid_o    (valid),
        .target_o   (tgt)
    );

    function automatic logic [63:0] rot(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic st_t fwd(input st_t s);
        st_t f;
        for (int r = 0; r < 5; r++) f[r] = s[r] ^ rot(s[r], FwdA[r]) ^ rot(s[r], FwdB[r]);
        return f;
    endfunction

    function automatic st_t rand_state();
        st_t s;
        for (int r = 0; r < 5; r++) s[r] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chki(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chks(input string tag, input st_t got, input st_t exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One full operation; diffused input is scrambled right after acceptance.
    task automatic run_op(input st_t orig, input string tag);
        int n;
        @(negedge clk);
        start = 1'b1;
        din   = fwd(orig);
        @(negedge clk);
        start = 1'b0;
        din   = rand_state();
        chk1({tag, " busy after accept"}, busy, 1'b1);
        chk1({tag, " valid cleared"}, valid, 1'b0);
        n = 1;
        while (done !== 1'b1 && n < 4 * Lat) begin
            @(negedge clk);
            n++;
        end
        chki({tag, " latency"}, n, Lat);
        chks({tag, " target"}, tgt, orig);
        chk1({tag, " valid at done"}, valid, 1'b1);
        chk1({tag, " busy at done"}, busy, 1'b0);
        @(negedge clk);
        chk1({tag, " done pulse width"}, done, 1'b0);
        chks({tag, " target hold"}, tgt, orig);
        chk1({tag, " valid hold"}, valid, 1'b1);
    endtask

    initial begin
        st_t x1, x2, vec;
        int  pulses, first, n;

        // Reset state
        repeat (2) @(negedge clk);
        chk1("reset busy", busy, 1'b0);
        chk1("reset done", done, 1'b0);
        chk1("reset valid", valid, 1'b0);
        chks("reset target", tgt, '0);
        rstn = 1'b1;

        // Boundary patterns and the directed vector set
        run_op('0, "zeros");
        run_op({5{64'hFFFF_FFFF_FFFF_FFFF}}, "ones");
        vec[0] = 64'h0123456789ABCDEF;
        vec[1] = 64'hFEDCBA9876543210;
        vec[2] = 64'h0F0F0F0F0F0F0F0F;
        vec[3] = 64'h8000000000000001;
        vec[4] = 64'hDEADBEEFCAFEF00D;
        run_op(vec, "vector");

        // start held high for 10 cycles, input disturbed during the first run
        x1 = rand_state();
        x2 = rand_state();
        pulses = 0;
        first  = 0;
        @(negedge clk);
        start = 1'b1;
        din   = fwd(x1);
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            din = (e < Lat) ? rand_state() : fwd(x2);
            if (done === 1'b1) begin
                pulses++;
                if (first == 0) begin
                    first = e;
                    chks("held first result", tgt, x1);
                end
            end
            if (e == Lat + 1) begin
                chk1("held second accept busy", busy, 1'b1);
                chk1("held second accept valid", valid, 1'b0);
            end
        end
        start = 1'b0;
        chki("held first done edge", first, Lat);
        chki("held done count", pulses, 10 / Lat);
        n = 0;
        while (done !== 1'b1 && n < 4 * Lat) begin
            @(negedge clk);
            n++;
        end
        chk1("held final done seen", done, 1'b1);
        chks("held final result", tgt, x2);

        // Reset in the middle of a run
        @(negedge clk);
        start = 1'b1;
        din   = fwd(rand_state());
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk1("midreset busy", busy, 1'b0);
        chk1("midreset done", done, 1'b0);
        chk1("midreset valid", valid, 1'b0);
        chks("midreset target", tgt, '0);
        @(negedge clk);
        rstn   = 1'b1;
        pulses = 0;
        repeat (2 * Lat) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        chki("midreset no done", pulses, 0);
        chk1("midreset idle", busy, 1'b0);
        run_op(vec, "after reset");

        // Random round trips
        for (int i = 0; i < 1000; i++) run_op(rand_state(), "random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inverse_diffusion_layer.md
INVERSE_DIFFUSION_LAYER -- requirements
Module: inverse_diffusion_layer

Interface
REQ-001 The block SHALL have no parameters; all rotation amounts SHALL be fixed by the Ascon linear layer.
REQ-002 clock_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 resetb_i  input  1  reset, asynchronous, active-low.
REQ-004 start_i  input  1  request to invert the value on diffused_i, sampled on a rising edge.
REQ-005 diffused_i  input  type_state (5 x 64)  diffused state to invert.
REQ-006 busy_o  output  1  computation in progress.
REQ-007 done_o  output  1  one-cycle pulse marking the cycle the result becomes valid.
REQ-008 valid_o  output  1  held high while target_o holds a completed result.
REQ-009 target_o  output  type_state (5 x 64)  recovered pre-diffusion state, taken from the internal state register.

Function
REQ-010 Row r forward map SHALL be L_r(x) = x ^ ror(x,a_r) ^ ror(x,b_r), with (a,b) = (19,28), (61,39), (1,6), (10,17), (7,41) for rows 0..4.
REQ-011 The block SHALL compute L_r^-1 = L_r^63 as six steps k = 0..5; step k SHALL be x <= x ^ ror(x,(a_r*2^k) mod 64) ^ ror(x,(b_r*2^k) mod 64).
REQ-012 A rotation by 0 SHALL equal the identity; for example, row 0 step 4 reduces to ror(x,48).
REQ-013 The FSM SHALL have two states, IDLE and RUN, with a 3-bit step counter.
REQ-014 In IDLE, when start_i = 1, the next edge SHALL load the register with step 0 applied to diffused_i, set the counter to 1, enter RUN, and clear valid_o.
REQ-015 In RUN, each edge SHALL apply the step indexed by the counter and then increment the counter.
REQ-016 The edge that applies step 5 SHALL return the FSM to IDLE, assert done_o for exactly one cycle, and set valid_o.
REQ-017 Latency SHALL be 6 clock edges, counted from the edge sampling start_i up to and including the edge raising done_o.
REQ-018 busy_o SHALL be 1 exactly while in RUN.
REQ-019 start_i SHALL be ignored while busy_o = 1; diffused_i SHALL be sampled only on the accepting edge.
REQ-020 A start_i on the same edge that raises done_o SHALL be ignored (the FSM is still in RUN).
REQ-021 A start_i in the following IDLE cycle SHALL be accepted; back-to-back throughput SHALL therefore be one result per 7 cycles.
REQ-022 target_o SHALL hold the last result unchanged until the next accepted start_i.
REQ-023 The five rows SHALL be processed in parallel and independently.

Reset
REQ-024 When resetb_i = 0, the block SHALL immediately drive state to IDLE, the counter to 0, the register to all zeros, and busy_o, done_o and valid_o to 0.
REQ-025 A reset during RUN SHALL abort the operation with no done_o pulse; the first accepted start_i after reset release SHALL behave as from power-up.

Configuration
REQ-026 Macro INV_DIFFUSION_UNROLL2_EN SHALL select the step structure.
REQ-027 When INV_DIFFUSION_UNROLL2_EN is defined, each edge SHALL apply two consecutive steps (0-1, 2-3, 4-5); latency SHALL be 3 edges and back-to-back throughput one result per 4 cycles.
REQ-028 When INV_DIFFUSION_UNROLL2_EN is undefined, the block SHALL behave as in REQ-011 to REQ-021 (one step per edge).
REQ-029 The computed results SHALL be identical in both configurations.

Verification
REQ-030 diffused_i = all rows 0x0000000000000000, start pulse -> done_o after 6 edges, target_o all zero, valid_o = 1.
REQ-031 diffused_i = all rows 0xFFFFFFFFFFFFFFFF -> target_o all rows 0xFFFFFFFFFFFFFFFF.
REQ-032 Round trip: rows 0x0123456789ABCDEF, 0xFEDCBA9876543210, 0x0F0F0F0F0F0F0F0F, 0x8000000000000001, 0xDEADBEEFCAFEF00D applied to the forward diffusion layer, its output fed to this block -> target_o equals the original rows; repeat with 1000 random states.
REQ-033 start_i held high for 10 cycles -> exactly one done_o pulse at edge 6; the second start accepted at edge 7; diffused_i changes during RUN do not alter the result.
REQ-034 resetb_i low at edge 3 of RUN -> busy_o, done_o, valid_o and target_o all 0 at once; no done_o pulse follows.
REQ-035 With INV_DIFFUSION_UNROLL2_EN defined, REQ-030 to REQ-032 -> same values, with done_o at edge 3.
